button_conditioner: RTL and testbench

Multi-channel button front end: synchronizer, debouncer, press/release edge generation, long-press detection and optional auto-repeat.
All stages are merged into one block with a per-channel FSM. The block sits between the board button/switch pins and the UART/ALU control logic.
It supersedes the single-edge parser chain by adding release events, hold timing and an asynchronous active-low reset.

---
 rtl/button_conditioner.sv | 187 ++++++++++++++++++
 tb/tb_button_conditioner.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - multi-channel button synchronizer, debouncer, press/release/long-press pulse generator
// Auto-repeat in the HELD state is compiled in only when BUTTON_CONDITIONER_AUTOREPEAT_EN is defined.
module button_conditioner #(
  parameter int WIDTH          = 4,
  parameter int SYNC_STAGES    = 2,
  parameter int SAMPLE_CNT_MAX = 25000,
  parameter int PULSE_CNT_MAX  = 150,
  parameter int HOLD_TICKS     = 50000,
  parameter int REPEAT_TICKS   = 10000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] level,
  output logic [WIDTH-1:0] press,
  output logic [WIDTH-1:0] release_pulse,
  output logic [WIDTH-1:0] long_press,
  output logic [WIDTH-1:0] repeat_pulse
);

  localparam int SW = $clog2(SAMPLE_CNT_MAX + 1);
  localparam int CW = $clog2(PULSE_CNT_MAX + 1);
  localparam int HW = $clog2(HOLD_TICKS + 1);

  localparam logic [SW-1:0] SCNT_LAST = SW'(SAMPLE_CNT_MAX - 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(PULSE_CNT_MAX - 1);
  localparam logic [CW-1:0] CNT_MAX   = CW'(PULSE_CNT_MAX);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_TICKS - 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(HOLD_TICKS);

  if (SYNC_STAGES < 2 || SAMPLE_CNT_MAX < 1 || PULSE_CNT_MAX < 1 ||
      HOLD_TICKS < 1 || REPEAT_TICKS < 1) begin : g_param_check
    $error("button_conditioner: illegal parameter value");
  end

  typedef enum logic [1:0] {IDLE, DEBOUNCE, PRESSED, HELD} state_t;

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [SW-1:0]    scnt;
  logic             tick;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
    end else begin
      sync_q[0] <= in;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
    end
  end

  // Shared sample-tick divider; every channel samples on the same tick.
  assign tick = (scnt == SCNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    scnt <= '0;
    else if (tick) scnt <= '0;
    else           scnt <= scnt + SW'(1);
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    state_t        state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [HW-1:0] hcnt, hcnt_nx;
    logic          s;
    logic          level_q, press_q, release_q, long_q;
    logic          level_nx, press_nx, release_nx, long_nx;

    assign s = sync_q[SYNC_STAGES-1][i];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state     <= IDLE;
        cnt       <= '0;
        hcnt      <= '0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        long_q    <= 1'b0;
      end else begin
        state     <= state_nx;
        cnt       <= cnt_nx;
        hcnt      <= hcnt_nx;
        level_q   <= level_nx;
        press_q   <= press_nx;
        release_q <= release_nx;
        long_q    <= long_nx;
      end
    end

    // A low synchronized input is checked before the tick so release always wins.
    always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      hcnt_nx  = hcnt;
      case (state)
        IDLE: begin
          if (s && tick) begin
            cnt_nx = CW'(1);
            if (PULSE_CNT_MAX == 1) begin
              state_nx = PRESSED;
              hcnt_nx  = '0;
            end else begin
              state_nx = DEBOUNCE;
            end
          end
        end
        DEBOUNCE: begin
          if (!s) begin
            state_nx = IDLE;
            cnt_nx   = '0;
          end else if (tick) begin
            if (cnt == CNT_LAST) begin
              cnt_nx   = CNT_MAX;
              state_nx = PRESSED;
              hcnt_nx  = '0;
            end else begin
              cnt_nx = cnt + CW'(1);
            end
          end
        end
        PRESSED: begin
          if (!s) begin
            state_nx = IDLE;
            cnt_nx   = '0;
            hcnt_nx  = '0;
          end else if (tick) begin
            if (hcnt == HOLD_LAST) begin
              hcnt_nx  = HOLD_MAX;
              state_nx = HELD;
            end else begin
              hcnt_nx = hcnt + HW'(1);
            end
          end
        end
        HELD: begin
          if (!s) begin
            state_nx = IDLE;
            cnt_nx   = '0;
            hcnt_nx  = '0;
          end
        end
        default: state_nx = IDLE;
      endcase
    end

    always_comb begin
      level_nx   = (state_nx == PRESSED) || (state_nx == HELD);
      press_nx   = (state_nx == PRESSED) && ((state == IDLE) || (state == DEBOUNCE));
      release_nx = (state_nx == IDLE) && ((state == PRESSED) || (state == HELD));
      long_nx    = (state == PRESSED) && (state_nx == HELD);
    end

    assign level[i]         = level_q;
    assign press[i]         = press_q;
    assign release_pulse[i] = release_q;
    assign long_press[i]    = long_q;

`ifdef BUTTON_CONDITIONER_AUTOREPEAT_EN
    localparam int            RW       = $clog2(REPEAT_TICKS + 1);
    localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_TICKS - 1);

    logic [RW-1:0] rcnt;
    logic          repeat_q;
    logic          rep_fire;

    // rcnt restarts on every entry to HELD, so the first repeat trails long_press by REPEAT_TICKS.
    assign rep_fire = (state == HELD) && s && tick && (rcnt == REP_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rcnt     <= '0;
        repeat_q <= 1'b0;
      end else begin
        repeat_q <= rep_fire;
        if (state != HELD || !s)  rcnt <= '0;
        else if (rep_fire)        rcnt <= '0;
        else if (tick)            rcnt <= rcnt + RW'(1);
      end
    end

    assign repeat_pulse[i] = repeat_q;
`else
    assign repeat_pulse[i] = 1'b0;
`endif
  end

endmodule

// File: tb/tb_button_conditioner.sv
// tb/tb_button_conditioner.sv - directed bench for button_conditioner with a tick-count reference model
// Works with BUTTON_CONDITIONER_AUTOREPEAT_EN defined or undefined.
module tb_button_conditioner;

  localparam int W    = 2;
  localparam int SYNC = 2;
  localparam int S    = 4;
  localparam int P    = 3;
  localparam int H    = 5;
  localparam int R    = 2;
`ifdef BUTTON_CONDITIONER_AUTOREPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] in;
  logic [W-1:0] level, press, release_pulse, long_press, repeat_pulse;

  button_conditioner #(
    .WIDTH(W), .SYNC_STAGES(SYNC), .SAMPLE_CNT_MAX(S),
    .PULSE_CNT_MAX(P), .HOLD_TICKS(H), .REPEAT_TICKS(R)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in(in), .level(level), .press(press),
    .release_pulse(release_pulse), .long_press(long_press), .repeat_pulse(repeat_pulse)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: each channel counts ticks seen while its synchronized input stays high.
  int           th [W];
  int           mcnt;
  logic [W-1:0] sh [SYNC];
  logic [W-1:0] m_level, m_press, m_rel, m_long, m_rep;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < W; c++) th[c] = 0;
      for (int k = 0; k < SYNC; k++) sh[k] = '0;
      mcnt = 0;
      m_level = '0; m_press = '0; m_rel = '0; m_long = '0; m_rep = '0;
    end else begin
      m_press = '0; m_rel = '0; m_long = '0; m_rep = '0;
      for (int c = 0; c < W; c++) begin
        if (!sh[SYNC-1][c]) begin
          m_rel[c]   = m_level[c];
          m_level[c] = 1'b0;
          th[c]      = 0;
        end else if (mcnt == S - 1) begin
          th[c]++;
          m_press[c] = (th[c] == P);
          m_long[c]  = (th[c] == P + H);
          m_rep[c]   = AR && (th[c] > P + H) && ((th[c] - P - H) % R == 0);
          m_level[c] = (th[c] >= P);
        end
      end
      for (int k = SYNC - 1; k > 0; k--) sh[k] = sh[k-1];
      sh[0] = in;
      mcnt  = (mcnt + 1) % S;
    end
  end

  always @(posedge clk) cyc++;

  int n_press [W], n_rel [W], n_long [W], n_rep [W], n_lvl [W];
  int t_press [W], t_rel [W], t_long [W], t_mark [W];
  int gap_err = 0;

  initial begin
    for (int c = 0; c < W; c++) begin
      n_press[c] = 0; n_rel[c] = 0; n_long[c] = 0; n_rep[c] = 0; n_lvl[c] = 0;
      t_press[c] = 0; t_rel[c] = 0; t_long[c] = 0; t_mark[c] = 0;
    end
  end

  always @(posedge clk) begin
    #2;
    check("outputs_vs_model",
          {22'd0, level, press, release_pulse, long_press, repeat_pulse},
          {22'd0, m_level, m_press, m_rel, m_long, m_rep});
    for (int c = 0; c < W; c++) begin
      if (press[c])         begin n_press[c]++; t_press[c] = cyc; end
      if (release_pulse[c]) begin n_rel[c]++;   t_rel[c]   = cyc; end
      if (long_press[c])    begin n_long[c]++;  t_long[c]  = cyc; t_mark[c] = cyc; end
      if (repeat_pulse[c]) begin
        n_rep[c]++;
        if (cyc - t_mark[c] != R * S) gap_err++;
        t_mark[c] = cyc;
      end
      if (level[c]) n_lvl[c]++;
    end
  end

  int t0, tf, p0, p1, r0, r1, l0, l1, g0;
  bit found;

  initial begin
    rst_n = 1'b0;
    in    = 2'b11;
    repeat (5) @(negedge clk);
    check("reset_outputs", {22'd0, level, press, release_pulse, long_press, repeat_pulse}, 32'd0);

    rst_n = 1'b1;
    t0    = cyc;
    found = 1'b0;
    for (int k = 0; k < 30 && !found; k++) begin
      @(negedge clk);
      if (press != '0) found = 1'b1;
    end
    check("reset_press_both", {30'd0, press}, 32'd3);
    check("reset_press_window", {31'd0, (cyc - t0 >= 11) && (cyc - t0 <= 15)}, 32'd1);
    in = 2'b00;
    repeat (12) @(negedge clk);

    p0 = n_press[0]; r0 = n_rel[0]; l0 = n_lvl[0];
    for (int k = 0; k < 40; k++) begin
      if (k % 3 == 0) in[0] = ~in[0];
      @(negedge clk);
    end
    in[0] = 1'b0;
    repeat (12) @(negedge clk);
    check("bounce_press", n_press[0] - p0, 32'd0);
    check("bounce_release", n_rel[0] - r0, 32'd0);
    check("bounce_level", n_lvl[0] - l0, 32'd0);

    p0 = n_press[0]; r0 = n_rel[0]; l0 = n_long[0];
    in[0] = 1'b1;
    repeat (60) @(negedge clk);
    in[0] = 1'b0;
    tf    = cyc;
    repeat (12) @(negedge clk);
    check("clean_press_count", n_press[0] - p0, 32'd1);
    check("clean_long_count", n_long[0] - l0, 32'd1);
    check("clean_long_delay", t_long[0] - t_press[0], 32'd20);
    check("clean_release_count", n_rel[0] - r0, 32'd1);
    check("clean_release_delay", t_rel[0] - tf, 32'd3);

    p0 = n_rep[0]; g0 = gap_err;
    in[0] = 1'b1;
    repeat (100) @(negedge clk);
    in[0] = 1'b0;
    repeat (12) @(negedge clk);
`ifdef BUTTON_CONDITIONER_AUTOREPEAT_EN
    check("repeat_count", {31'd0, (n_rep[0] - p0) >= 5}, 32'd1);
`else
    check("repeat_none", n_rep[0] - p0, 32'd0);
`endif
    check("repeat_gap", gap_err - g0, 32'd0);

    r1 = n_rel[1]; l1 = n_long[1];
    in[1] = 1'b1;
    repeat (50) @(negedge clk);
    check("hold_long", n_long[1] - l1, 32'd1);
    check("hold_level", {31'd0, level[1]}, 32'd1);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("midreset_outputs", {22'd0, level, press, release_pulse, long_press, repeat_pulse}, 32'd0);
    rst_n = 1'b1;
    p1    = n_press[1];
    found = 1'b0;
    for (int k = 0; k < 30 && !found; k++) begin
      @(negedge clk);
      if (n_press[1] != p1) found = 1'b1;
    end
    check("midreset_repress", {31'd0, found}, 32'd1);
    check("midreset_no_release", n_rel[1] - r1, 32'd0);
    in[1] = 1'b0;
    repeat (12) @(negedge clk);
    check("midreset_final_release", n_rel[1] - r1, 32'd1);

    p0 = n_press[0]; p1 = n_press[1]; r0 = n_rel[0];
    in = 2'b11;
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge clk);
      if (th[0] == P - 1 && mcnt == 1) found = 1'b1;
    end
    check("sim_align", {31'd0, found}, 32'd1);
    in[0] = 1'b0;
    repeat (12) @(negedge clk);
    check("sim_press0", n_press[0] - p0, 32'd0);
    check("sim_release0", n_rel[0] - r0, 32'd0);
    check("sim_press1", n_press[1] - p1, 32'd1);
    check("sim_level", {30'd0, level}, 32'd2);
    in[1] = 1'b0;
    repeat (12) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
